dspm_rr_ctrl: RTL
=================

Name: dspm_rr_ctrl

Overview:
- Next-generation D-cache scratchpad (SPM) controller.
- Arbitrates NR_PORTS requesters onto NR_WAYS data SRAM banks. Arbitration is round-robin, not fixed priority.
- Fully pipelined: one request accepted per cycle, with up to LATENCY reads in flight.
- Sits between the load/store unit ports and the cache data memories while the data cache runs in SPM mode.

Parameters:
- NR_PORTS, 3, number of requester ports (>=1).
- NR_WAYS, 4, number of SRAM ways/banks (power of two).
- LINE_WIDTH, 128, SRAM payload bits per line.
- DATA_WIDTH, 64, port word width; LINE_WIDTH/DATA_WIDTH is a power of two.
- MEMORY_WIDTH, 172, full SRAM row width (payload plus tag/status bits).
- ADDR_WIDTH, 64, port address width.
- IDX_WIDTH, 12, SRAM index plus byte-offset bits.
- LATENCY, 1, SRAM read latency in cycles (>=1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- active_ways_i  in  NR_WAYS  ways usable as SPM.
- req_i  in  NR_PORTS  request valid.
- we_i  in  NR_PORTS  1 = write.
- addr_i  in  NR_PORTS x ADDR_WIDTH  byte address.
- wdata_i  in  NR_PORTS x DATA_WIDTH  write data.
- be_i  in  NR_PORTS x DATA_WIDTH/8  byte enables.
- gnt_o  out  NR_PORTS  request accepted.
- rvalid_o  out  NR_PORTS  read data valid.
- rdata_o  out  NR_PORTS x DATA_WIDTH  read data.
- err_o  out  NR_PORTS  error qualifier, valid with gnt_o (writes) or rvalid_o (reads).
- sram_req_o  out  NR_WAYS  per-way enable.
- sram_addr_o  out  IDX_WIDTH  row address.
- sram_we_o  out  1  write enable.
- sram_wdata_o  out  MEMORY_WIDTH  write row.
- sram_be_o  out  (MEMORY_WIDTH+7)/8  byte enables.
- sram_rdata_i  in  NR_WAYS x MEMORY_WIDTH  read rows.

Behaviour:
- Reset:
  - All outputs are 0.
  - Round-robin pointer is 0.
  - Response pipeline is cleared. Reads in flight at reset are dropped and never answered.
- Arbitration:
  - Combinational. The winner is the first requesting port at or after the pointer, wrapping modulo NR_PORTS.
  - gnt_o[winner]=1 in the same cycle, for reads and writes.
  - Pointer becomes winner+1 (wrapping) on each grant. It holds when there is no request.
  - At most one grant per cycle; losers keep req_i high and retry.
- Address decode:
  - way = addr[IDX_WIDTH +: log2(NR_WAYS)].
  - word offset = addr[log2(LINE_WIDTH/8)-1 : log2(DATA_WIDTH/8)].
  - sram_addr_o = addr[IDX_WIDTH-1:0].
- Write to an active way:
  - sram_req_o[way]=1 and sram_we_o=1.
  - The word is placed at its offset and all other payload bits are 0.
  - Payload byte enables are the port's be at the offset; all tag/status byte enables are 1, so tag bits are zeroed.
- Read to an active way:
  - sram_req_o[way]=1 and sram_we_o=0.
  - {port, way, offset, err=0} enters a LATENCY-deep shift pipeline.
  - rvalid_o[port] pulses exactly LATENCY cycles after the grant cycle. rdata_o is the selected word of sram_rdata_i[way].
- Inactive way (active_ways_i[way]=0):
  - No SRAM access.
  - Write: granted with err_o=1, data discarded.
  - Read: granted and still answered after LATENCY with rdata 0xCA11AB1E_BADCAB1E (truncated/zero-extended to DATA_WIDTH) and err_o=1.
- Ordering:
  - Back-to-back grants each produce their own response in grant order.
  - Two responses to the same port in consecutive cycles are legal.
- active_ways_i is sampled at grant; later changes do not affect reads already in flight.
- rdata_o is 0 whenever rvalid_o is 0.

Optional Feature:
- Macro: DSPM_PERF_CNT_EN.
- Defined:
  - Adds output conflict_cnt_o, NR_PORTS x 32.
  - Each counter increments every cycle the port has req_i=1 and gnt_o=0, and saturates at 0xFFFFFFFF.
  - Counters clear on rst_i.
- Undefined: the port and the counters are absent and the remaining behaviour is identical.

Test Plan:
- Port0 writes 0xDEADBEEF_01234567 to way 1, offset 1, be=0xFF, then reads it back; LATENCY=2 → read rvalid_o[0] two cycles after its grant, same data, err_o=0.
- Ports 0, 1 and 2 all hold requests for 6 cycles → grants 0,1,2,0,1,2; pointer wraps.
- Read to way 3 with active_ways_i=0b0111 → no sram_req_o; rvalid_o after LATENCY with 0xCA11AB1E_BADCAB1E and err_o=1.
- Four back-to-back reads from port 1 at LATENCY=3 → four consecutive rvalid_o[1] pulses in order, starting 3 cycles after the first grant.
- rst_i asserted with 2 reads in flight → no rvalid_o afterwards; next grant goes to port 0.
- With DSPM_PERF_CNT_EN defined, port 2 blocked 5 cycles by ports 0 and 1 → conflict_cnt_o[2]=5.

Source files
------------

// File: rtl/dspm_rr_ctrl.sv
// Scratchpad-mode data-cache controller: round-robin arbitration of NR_PORTS requesters onto NR_WAYS SRAM banks.
// Optional macro DSPM_PERF_CNT_EN adds per-port saturating conflict counters (conflict_cnt_o).
module dspm_rr_ctrl #(
  parameter int unsigned NR_PORTS     = 3,
  parameter int unsigned NR_WAYS      = 4,
  parameter int unsigned LINE_WIDTH   = 128,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned MEMORY_WIDTH = 172,
  parameter int unsigned ADDR_WIDTH   = 64,
  parameter int unsigned IDX_WIDTH    = 12,
  parameter int unsigned LATENCY      = 1
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [NR_WAYS-1:0]                      active_ways_i,
  input  logic [NR_PORTS-1:0]                     req_i,
  input  logic [NR_PORTS-1:0]                     we_i,
  input  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0]     addr_i,
  input  logic [NR_PORTS-1:0][DATA_WIDTH-1:0]     wdata_i,
  input  logic [NR_PORTS-1:0][DATA_WIDTH/8-1:0]   be_i,
  output logic [NR_PORTS-1:0]                     gnt_o,
  output logic [NR_PORTS-1:0]                     rvalid_o,
  output logic [NR_PORTS-1:0][DATA_WIDTH-1:0]     rdata_o,
  output logic [NR_PORTS-1:0]                     err_o,
  output logic [NR_WAYS-1:0]                      sram_req_o,
  output logic [IDX_WIDTH-1:0]                    sram_addr_o,
  output logic                                    sram_we_o,
  output logic [MEMORY_WIDTH-1:0]                 sram_wdata_o,
  output logic [(MEMORY_WIDTH+7)/8-1:0]           sram_be_o,
  input  logic [NR_WAYS-1:0][MEMORY_WIDTH-1:0]    sram_rdata_i
`ifdef DSPM_PERF_CNT_EN
  ,
  output logic [NR_PORTS-1:0][31:0]               conflict_cnt_o
`endif
);

  localparam int unsigned PORT_W  = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam int unsigned WAY_W   = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;
  localparam int unsigned WORDS   = LINE_WIDTH / DATA_WIDTH;
  localparam int unsigned OFF_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned OFF_LSB = $clog2(DATA_WIDTH / 8);
  localparam int unsigned DBE     = DATA_WIDTH / 8;
  localparam int unsigned LBE     = LINE_WIDTH / 8;
  localparam int unsigned BE_W    = (MEMORY_WIDTH + 7) / 8;
  localparam logic [63:0] ERR_PATTERN = 64'hCA11AB1E_BADCAB1E;

  typedef struct packed {
    logic              valid;
    logic [PORT_W-1:0] port;
    logic [WAY_W-1:0]  way;
    logic [OFF_W-1:0]  off;
    logic              err;
  } rsp_t;

  logic [PORT_W-1:0]     ptr_q;
  logic                  win_valid;
  logic [PORT_W-1:0]     win;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_we;
  logic [WAY_W-1:0]      sel_way;
  logic [OFF_W-1:0]      sel_off;
  logic                  way_active;
  logic [LINE_WIDTH-1:0] wline;
  logic [LBE-1:0]        bline;
  rsp_t                  new_rsp;
  rsp_t                  head;
  rsp_t                  pipe_q [LATENCY];

  function automatic logic [PORT_W-1:0] wrap_add(input logic [PORT_W-1:0] base, input int unsigned inc);
    int unsigned sum;
    sum = 32'(base) + inc;
    if (sum >= NR_PORTS) sum = sum - NR_PORTS;
    return PORT_W'(sum);
  endfunction

  // First requester at or after the pointer wins; nothing is granted while in reset
  always_comb begin
    win_valid = 1'b0;
    win       = '0;
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      if (!win_valid && req_i[wrap_add(ptr_q, i)]) begin
        win_valid = 1'b1;
        win       = wrap_add(ptr_q, i);
      end
    end
    if (rst_i) win_valid = 1'b0;
  end

  always_comb begin
    sel_addr   = addr_i[win];
    sel_we     = we_i[win];
    sel_way    = sel_addr[IDX_WIDTH +: WAY_W];
    sel_off    = (WORDS > 1) ? sel_addr[OFF_LSB +: OFF_W] : '0;
    way_active = active_ways_i[sel_way];
  end

  // SRAM drive: writes zero the rest of the payload and force the tag/status bytes on
  always_comb begin
    sram_req_o   = '0;
    sram_addr_o  = '0;
    sram_we_o    = 1'b0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    wline        = '0;
    bline        = '0;
    if (win_valid && way_active) begin
      sram_req_o  = NR_WAYS'(1) << sel_way;
      sram_we_o   = sel_we;
      sram_addr_o = sel_addr[IDX_WIDTH-1:0];
      if (sel_we) begin
        wline[32'(sel_off)*DATA_WIDTH +: DATA_WIDTH] = wdata_i[win];
        bline[32'(sel_off)*DBE +: DBE]               = be_i[win];
        sram_wdata_o                                 = MEMORY_WIDTH'(wline);
        sram_be_o                                    = '1;
        sram_be_o[LBE-1:0]                           = bline;
      end
    end
  end

  always_comb begin
    new_rsp       = '0;
    new_rsp.valid = win_valid && !sel_we;
    new_rsp.port  = win;
    new_rsp.way   = sel_way;
    new_rsp.off   = sel_off;
    new_rsp.err   = !way_active;
  end

  assign head = pipe_q[LATENCY-1];

  // Grants, write errors and read responses leaving the last pipeline stage
  always_comb begin
    gnt_o    = '0;
    err_o    = '0;
    rvalid_o = '0;
    rdata_o  = '0;
    if (win_valid) begin
      gnt_o[win] = 1'b1;
      if (sel_we && !way_active) err_o[win] = 1'b1;
    end
    if (head.valid && !rst_i) begin
      rvalid_o[head.port] = 1'b1;
      if (head.err) begin
        err_o[head.port]   = 1'b1;
        rdata_o[head.port] = DATA_WIDTH'(ERR_PATTERN);
      end else begin
        rdata_o[head.port] = sram_rdata_i[head.way][32'(head.off)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      if (win_valid) ptr_q <= wrap_add(win, 1);
      pipe_q[0] <= new_rsp;
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

`ifdef DSPM_PERF_CNT_EN
  // Cycles a port waited with its request pending, saturating
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conflict_cnt_o <= '0;
    end else begin
      for (int p = 0; p < NR_PORTS; p++) begin
        if (req_i[p] && !gnt_o[p] && (conflict_cnt_o[p] != 32'hFFFF_FFFF))
          conflict_cnt_o[p] <= conflict_cnt_o[p] + 32'd1;
      end
    end
  end
`endif

  // Address bits above the way field and SRAM tag/status bits are never inspected
  logic unused_bits;
  assign unused_bits = ^{addr_i, sram_rdata_i};

endmodule
